// File: rtl/xor_descrambler.sv
// XOR descrambler: recovers words scrambled with a 16-bit Galois LFSR keystream.
// A seed load starts (or restarts) the keystream; each accepted word advances the
// LFSR by one step and is presented on a single-entry output register.
module xor_descrambler #(
    parameter int unsigned w = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         seed_load,
    input  logic [15:0]  seed,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [w-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [w-1:0] out_data,
    output logic [15:0]  word_cnt,
    output logic         running
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [15:0] LfsrReset = 16'h0001;
    localparam logic [15:0] LfsrAlt   = 16'hACE1;  // replaces an all-zero seed
    localparam logic [15:0] LfsrTaps  = 16'hB400;

    state_e         state_q, state_d;
    logic [15:0]    lfsr_q, lfsr_d, lfsr_step;
    logic [15:0]    cnt_q, cnt_d;
    logic           out_valid_q, out_valid_d;
    logic [w-1:0]   out_data_q, out_data_d;
    logic [w-1:0]   keystream;
    logic           accept;

    // Keystream replicates the 16-bit LFSR across the word width.
    for (genvar g = 0; g < int'(w); g++) begin : g_ks
        assign keystream[g] = lfsr_q[g % 16];
    end

    assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrTaps : 16'h0000);

    assign running   = (state_q == StRun);
    // A seed load blocks acceptance so the new keystream starts cleanly.
    assign in_ready  = running & ~seed_load & (~out_valid_q | out_ready);
    assign accept    = in_valid & in_ready;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign word_cnt  = cnt_q;

    // State transitions: a seed load is the only way into RUN; only reset leaves it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (seed_load) state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state: seed load beats accept, accept beats drain.
    always_comb begin
        lfsr_d      = lfsr_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (seed_load) begin
            lfsr_d      = (seed == 16'h0000) ? LfsrAlt : seed;
            cnt_d       = 16'h0000;
            out_valid_d = 1'b0;  // any undrained word is dropped
        end else if (accept) begin
            out_data_d  = in_data ^ keystream;
            out_valid_d = 1'b1;
            lfsr_d      = lfsr_step;
            cnt_d       = cnt_q + 16'd1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            lfsr_q      <= LfsrReset;
            cnt_q       <= 16'h0000;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_xor_descrambler.sv
// Testbench for xor_descrambler: queue-based reference model, separate output
// monitor, directed scenarios plus randomized round-trip traffic.
module tb_xor_descrambler;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         seed_load = 1'b0;
    logic [15:0]  seed = 16'h0000;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [15:0]  word_cnt;
    logic         running;

    int checks = 0;
    int failures = 0;

    // Expected outputs in flight, and words actually drained by the monitor.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] rx[$];

    // Reference model state.
    bit           m_run = 1'b0;
    logic [15:0]  m_lfsr = 16'h0001;
    logic [15:0]  m_cnt = 16'h0000;

    xor_descrambler #(.w(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .seed      (seed),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .word_cnt  (word_cnt),
        .running   (running)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [W-1:0] ks(input logic [15:0] l);
        logic [W-1:0] k;
        for (int i = 0; i < W; i++) k[i] = l[i % 16];
        return k;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_rx(input string name, input int idx, input logic [31:0] exp);
        logic [31:0] a;
        a = 'x;
        if (idx < rx.size()) a = 32'(rx[idx]);
        chk(name, a, exp);
    endtask

    // Monitor: at the falling edge, the word on the output (if any) must be the
    // oldest expected one; it is retired when downstream takes it at the next edge.
    always begin
        @(negedge clk);
        checks++;
        if (out_valid !== (exp_q.size() != 0)) begin
            failures++;
            $display("FAIL mon_out_valid: got %b want %b", out_valid, exp_q.size() != 0);
        end else if (out_valid) begin
            checks++;
            if (out_data !== exp_q[0]) begin
                failures++;
                $display("FAIL mon_out_data: got %h want %h", out_data, exp_q[0]);
            end
            if (out_ready) begin
                rx.push_back(out_data);
                void'(exp_q.pop_front());
            end
        end
    end

    // Reference model: just before each rising edge, predict handshake and state.
    always begin
        bit m_ready;
        @(negedge clk);
        #4;
        // Queue already reflects a drain happening this edge.
        m_ready = m_run && !seed_load && (exp_q.size() == 0);
        chk("mdl_in_ready", 32'(in_ready), 32'(m_ready));
        chk("mdl_running", 32'(running), 32'(m_run));
        chk("mdl_word_cnt", 32'(word_cnt), 32'(m_cnt));
        if (rst) begin
            m_run  = 1'b0;
            m_lfsr = 16'h0001;
            m_cnt  = 16'h0000;
            exp_q.delete();
        end else if (seed_load) begin
            m_run  = 1'b1;
            m_lfsr = (seed == 16'h0000) ? 16'hACE1 : seed;
            m_cnt  = 16'h0000;
            exp_q.delete();
        end else if (in_valid && m_ready) begin
            exp_q.push_back(in_data ^ ks(m_lfsr));
            m_lfsr = lfsr_next(m_lfsr);
            m_cnt  = m_cnt + 16'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        seed_load = 1'b0;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic load_seed(input logic [15:0] s);
        seed_load = 1'b1;
        seed = s;
        tick();
        seed_load = 1'b0;
    endtask

    // Offer one word until accepted; rnd randomizes in_valid and out_ready.
    task automatic send(input logic [W-1:0] d, input bit rnd);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        in_data = d;
        while (!done && n < 200) begin
            in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rnd) out_ready = ($urandom_range(0, 2) != 0);
            #1;
            done = in_valid && in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("drain_done", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] plain[$];
        logic [15:0]  l;
        logic [W-1:0] p;
        int acc;

        repeat (3) tick();
        rst = 1'b0;

        // Reset values.
        do_reset();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);

        // Known-answer back-to-back stream with seed 1.
        load_seed(16'h0001);
        chk("seed_running", 32'(running), 32'd1);
        out_ready = 1'b1;
        rx.delete();
        send(16'h1234, 1'b0);
        send(16'hB400, 1'b0);
        send(16'hFFFF, 1'b0);
        drain();
        chk("kat_count", 32'(rx.size()), 32'd3);
        chk_rx("kat_w0", 0, 32'h1235);
        chk_rx("kat_w1", 1, 32'h0000);
        chk_rx("kat_w2", 2, 32'hA5FF);
        chk("kat_word_cnt", 32'(word_cnt), 32'd3);

        // Idle ignores input.
        do_reset();
        in_valid = 1'b1;
        in_data = W'($urandom);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("idle_in_ready", 32'(in_ready), 32'd0);
            chk("idle_out_valid", 32'(out_valid), 32'd0);
            tick();
        end
        in_valid = 1'b0;

        // Zero seed substitutes ACE1.
        load_seed(16'h0000);
        rx.delete();
        send(16'h0000, 1'b0);
        drain();
        chk_rx("zero_seed", 0, 32'hACE1);

        // Stall holds output and freezes the LFSR.
        do_reset();
        load_seed(16'h0001);
        rx.delete();
        out_ready = 1'b0;
        send(16'h1234, 1'b0);
        in_data = 16'hB400;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_out_data", 32'(out_data), 32'h1235);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        send(16'hB400, 1'b0);
        drain();
        chk_rx("stall_w0", 0, 32'h1235);
        chk_rx("stall_w1", 1, 32'h0000);

        // Reseed discards a pending word.
        out_ready = 1'b0;
        send(16'h5555, 1'b0);
        load_seed(16'h0002);
        chk("reseed_discard", 32'(out_valid), 32'd0);
        chk("reseed_cnt", 32'(word_cnt), 32'd0);

        // Reset discards a pending word.
        send(W'($urandom), 1'b0);
        do_reset();
        chk("rst_discard", 32'(out_valid), 32'd0);
        chk("rst_discard_data", 32'(out_data), 32'd0);
        out_ready = 1'b1;

        // Word counter wrap.
        load_seed(16'h0001);
        out_ready = 1'b1;
        in_valid = 1'b1;
        acc = 0;
        for (int n = 0; n < 70000 && acc < 65536; n++) begin
            in_data = W'($urandom);
            #1;
            if (in_valid && in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        chk("wrap_accepted", 32'(acc), 32'd65536);
        chk("wrap_cnt0", 32'(word_cnt), 32'h0000);
        send(W'($urandom), 1'b0);
        chk("wrap_cnt1", 32'(word_cnt), 32'h0001);
        drain();

        // Round trip with random handshakes and a mid-stream reseed.
        do_reset();
        rx.delete();
        plain.delete();
        load_seed(16'hBEEF);
        l = 16'hBEEF;
        for (int i = 0; i < 24; i++) begin
            p = W'($urandom);
            plain.push_back(p);
            send(p ^ ks(l), 1'b1);
            l = lfsr_next(l);
        end
        drain();
        load_seed(16'h1357);
        l = 16'h1357;
        for (int i = 0; i < 24; i++) begin
            p = W'($urandom);
            plain.push_back(p);
            send(p ^ ks(l), 1'b1);
            l = lfsr_next(l);
        end
        drain();
        chk("rt_count", 32'(rx.size()), 32'(plain.size()));
        for (int i = 0; i < plain.size(); i++) chk_rx("rt_word", i, 32'(plain[i]));

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
